// File: rtl/tbird_pkg.sv
// Shared types for the T-bird turn-signal blocks: the per-channel debounce
// state, the light sequencer's state, and a helper that maps a debounce
// state to its conditioned level.
package tbird_pkg;

    typedef enum logic [1:0] {
        DB_LO      = 2'd0,
        DB_PEND_HI = 2'd1,
        DB_HI      = 2'd2,
        DB_PEND_LO = 2'd3
    } t_debounce_state;

    typedef enum logic [2:0] {
        LIGHT_IDLE = 3'd0,
        LIGHT_L1   = 3'd1,
        LIGHT_L2   = 3'd2,
        LIGHT_L3   = 3'd3,
        LIGHT_R1   = 3'd4,
        LIGHT_R2   = 3'd5,
        LIGHT_R3   = 3'd6,
        LIGHT_LR3  = 3'd7
    } t_light_state;

    // The accepted level is high in HI and while a fall is still pending.
    function automatic logic db_level(input t_debounce_state st);
        return (st == DB_HI) || (st == DB_PEND_LO);
    endfunction

endpackage

// File: rtl/tbird_input_cond_if.sv
// Switch-side bus of the input conditioner: the three raw switches and the
// three conditioned requests handed on to the light sequencer.
interface tbird_input_cond_if;
    logic left_sw;
    logic right_sw;
    logic haz_sw;
    logic left;
    logic right;
    logic haz;

    // Whoever drives the switches and consumes the requests.
    modport master (
        output left_sw, right_sw, haz_sw,
        input  left, right, haz
    );

    // The conditioner itself.
    modport slave (
        input  left_sw, right_sw, haz_sw,
        output left, right, haz
    );
endinterface

// File: rtl/tbird_debounce.sv
// One conditioning channel: two-flop synchronizer feeding a four-state
// debounce FSM. A level change is accepted only after DEBOUNCE_CYCLES
// consecutive synchronized samples of the new value; any reversal while
// pending drops back to the old stable state, so the output never glitches.
module tbird_debounce
    import tbird_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_b,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic            sync_p0;
    logic            sync_p1;
    t_debounce_state state;
    t_debounce_state state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    // Synchronizer: bring the asynchronous switch into the clock domain.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Next-state logic; the counter stops at CNT_MAX because the state
    // always leaves PEND_* on that count, so it cannot wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            DB_LO: begin
                if (sync_p1) begin
                    state_nxt = DB_PEND_HI;
                    cnt_nxt   = '0;
                end
            end
            DB_PEND_HI: begin
                if (!sync_p1) begin
                    state_nxt = DB_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = DB_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DB_HI: begin
                if (!sync_p1) begin
                    state_nxt = DB_PEND_LO;
                    cnt_nxt   = '0;
                end
            end
            DB_PEND_LO: begin
                if (sync_p1) begin
                    state_nxt = DB_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = DB_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered level; level is loaded from the next
    // state so it changes on the same edge the FSM enters HI or LO.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= DB_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= db_level(state_nxt);
        end
    end

endmodule

// File: rtl/tbird_input_cond.sv
// T-bird input conditioner: synchronizes and debounces the left, right and
// hazard switches independently (no left/right priority here; the sequencer
// resolves that).
// Build option TBIRD_HAZ_TOGGLE_EN: when defined, haz is a toggle register
// that flips one cycle after each debounced hazard press; otherwise haz is
// the debounced hazard level.
module tbird_input_cond
    import tbird_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    tbird_input_cond_if.slave  bus
);

    logic left_lvl;
    logic right_lvl;
    logic haz_lvl;

    tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk   (clk),
        .rst_b (rst_b),
        .raw   (bus.left_sw),
        .level (left_lvl)
    );

    tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk   (clk),
        .rst_b (rst_b),
        .raw   (bus.right_sw),
        .level (right_lvl)
    );

    tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_haz (
        .clk   (clk),
        .rst_b (rst_b),
        .raw   (bus.haz_sw),
        .level (haz_lvl)
    );

    assign bus.left  = left_lvl;
    assign bus.right = right_lvl;

`ifdef TBIRD_HAZ_TOGGLE_EN
    logic haz_lvl_q;
    logic haz_tog;

    // Hazard toggle: flip on each debounced rising edge, ignore falls.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            haz_lvl_q <= 1'b0;
            haz_tog   <= 1'b0;
        end else begin
            haz_lvl_q <= haz_lvl;
            if (haz_lvl && !haz_lvl_q) begin
                haz_tog <= ~haz_tog;
            end
        end
    end

    assign bus.haz = haz_tog;
`else
    assign bus.haz = haz_lvl;
`endif

endmodule

// File: tb/tb_tbird_input_cond.sv
// Scoreboard bench for tbird_input_cond with DEBOUNCE_CYCLES=4 (output
// latency 7 edges, 8 for the hazard toggle build).
module tb_tbird_input_cond;

    localparam int N = 4;
`ifdef TBIRD_HAZ_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    typedef struct {
        logic  l;
        logic  r;
        logic  h;
        string nm;
    } exp_t;

    logic clk;
    logic rst_b;
    int   checks;
    int   errors;
    exp_t q[$];

    tbird_input_cond_if bus ();

    tbird_input_cond #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (from just after a falling edge) and queue
    // the outputs expected after the following rising edge.
    task automatic cyc(input logic rb, input logic l, input logic r, input logic h,
                       input logic el, input logic er, input logic eh, input string nm);
        exp_t e;
        rst_b       = rb;
        bus.left_sw  = l;
        bus.right_sw = r;
        bus.haz_sw   = h;
        @(posedge clk);
        e.l  = el;
        e.r  = er;
        e.h  = eh;
        e.nm = nm;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare on falling edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({bus.left, bus.right, bus.haz} !== {e.l, e.r, e.h}) begin
                    errors++;
                    $display("FAIL %s @%0t: left/right/haz got %b%b%b want %b%b%b",
                             e.nm, $time, bus.left, bus.right, bus.haz, e.l, e.r, e.h);
                end
            end
        end
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        bus.left_sw  = 1'b1;
        bus.right_sw = 1'b1;
        bus.haz_sw   = 1'b1;
        #1;

        // Reset with all switches high, then release.
        for (int e = 1; e <= 3; e++) cyc(0, 1, 1, 1, 0, 0, 0, "reset_hold");
        for (int e = 1; e <= 9; e++)
            cyc(1, 1, 1, 1, e >= 7, e >= 7, TOG ? (e >= 8) : (e >= 7), "reset_release");
        for (int e = 1; e <= 8; e++)
            cyc(1, 0, 0, 0, e < 7, e < 7, TOG ? 1'b1 : (e < 7), "all_release");
        // Short reset pulse clears the hazard toggle as well.
        for (int e = 1; e <= 2; e++) cyc(0, 0, 0, 0, 0, 0, 0, "reset_clear");
        for (int e = 1; e <= 2; e++) cyc(1, 0, 0, 0, 0, 0, 0, "idle");

        // Clean left press and release.
        for (int e = 1; e <= 9; e++) cyc(1, 1, 0, 0, e >= 7, 0, 0, "left_press");
        for (int e = 1; e <= 9; e++) cyc(1, 0, 0, 0, e < 7, 0, 0, "left_release");

        // Right bounce: high 3, low 1, then held; final rise sampled on edge 5.
        for (int e = 1; e <= 3; e++) cyc(1, 0, 1, 0, 0, 0, 0, "bounce_hi");
        cyc(1, 0, 0, 0, 0, 0, 0, "bounce_lo");
        for (int e = 5; e <= 13; e++) cyc(1, 0, 1, 0, 0, e >= 11, 0, "bounce_hold");
        for (int e = 1; e <= 8; e++) cyc(1, 0, 0, 0, 0, e < 7, 0, "right_release");

        // Simultaneous left and right.
        for (int e = 1; e <= 9; e++) cyc(1, 1, 1, 0, e >= 7, e >= 7, 0, "simul_press");
        // Brief drop of left while high must be absorbed.
        for (int e = 1; e <= 2; e++) cyc(1, 0, 1, 0, 1, 1, 0, "left_dip");
        for (int e = 1; e <= 6; e++) cyc(1, 1, 1, 0, 1, 1, 0, "left_dip_recover");
        for (int e = 1; e <= 8; e++) cyc(1, 0, 0, 0, e < 7, e < 7, 0, "simul_release");

        // Two hazard presses of 10 cycles each.
        for (int e = 1; e <= 10; e++)
            cyc(1, 0, 0, 1, 0, 0, TOG ? (e >= 8) : (e >= 7), "haz_press1");
        for (int e = 1; e <= 10; e++)
            cyc(1, 0, 0, 0, 0, 0, TOG ? 1'b1 : (e < 7), "haz_release1");
        for (int e = 1; e <= 10; e++)
            cyc(1, 0, 0, 1, 0, 0, TOG ? (e < 8) : (e >= 7), "haz_press2");
        for (int e = 1; e <= 10; e++)
            cyc(1, 0, 0, 0, 0, 0, TOG ? 1'b0 : (e < 7), "haz_release2");

        // Reset in the middle of a pending hazard press.
        for (int e = 1; e <= 4; e++) cyc(1, 0, 0, 1, 0, 0, 0, "haz_pend");
        for (int e = 1; e <= 2; e++) cyc(0, 0, 0, 1, 0, 0, 0, "haz_pend_reset");
        for (int e = 1; e <= 9; e++)
            cyc(1, 0, 0, 1, 0, 0, TOG ? (e >= 8) : (e >= 7), "haz_requalify");
        for (int e = 1; e <= 8; e++)
            cyc(1, 0, 0, 0, 0, 0, TOG ? 1'b1 : (e < 7), "haz_final_release");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
